// File: rtl/i2c_burst_master.sv
// i2c_burst_master: single-master I2C engine for multi-byte read/write bursts.
// Define I2C_CLK_STRETCH_EN to let slaves stretch SCL through scl_in.
module i2c_burst_master #(
  parameter int CLK_DIV   = 3,
  parameter int MAX_BYTES = 16,
  localparam int LEN_W    = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wdata,
  output logic             wready,
  output logic [7:0]       rdata,
  output logic             rvalid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic             scl,
  input  logic             scl_in,
  inout  wire              sda
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_BYTE,
    WR_ACK, RD_BYTE, RD_ACK, STOP, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             rw_q, rw_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ack_q, ack_d;
  logic             nack_q, nack_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             sda_oe, sda_in, stall;
  logic             run, q_end, slot_end, smp;

  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign nack   = nack_q;
  assign busy   = (state_q != IDLE) && (state_q != DONE);

`ifdef I2C_CLK_STRETCH_EN
  assign stall = scl & ~scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall = 1'b0;
`endif

  // Bus waveform decoded from state and quarter position
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    unique case (state_q)
      START: begin
        scl    = (qtr_q != 2'd3);
        sda_oe = qtr_q[1];
      end
      ADDR, WR_BYTE: begin
        scl    = qtr_q[1];
        sda_oe = ~sh_q[7];
      end
      ADDR_ACK, WR_ACK, RD_BYTE: scl = qtr_q[1];
      RD_ACK: begin
        scl    = qtr_q[1];
        sda_oe = (rem_q != '0);
      end
      STOP: begin
        scl    = (qtr_q != 2'd0);
        sda_oe = (qtr_q != 2'd3);
      end
      default: ;
    endcase
  end

  // Quarter/slot timing strobes
  always_comb begin
    run      = busy && !stall;
    q_end    = run && (div_q == DIV_LAST);
    slot_end = q_end && (qtr_q == 2'd3);
    smp      = run && (qtr_q == 2'd2) && (div_q == '0);
  end

  // Next-state, datapath and handshake outputs
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    rw_d     = rw_q;
    rem_d    = rem_q;
    ack_d    = ack_q;
    nack_d   = nack_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wready   = 1'b0;
    done     = 1'b0;
    if (run) begin
      div_d = q_end ? '0 : div_q + DW'(1);
      qtr_d = q_end ? qtr_q + 2'd1 : qtr_q;
    end
    if (smp) ack_d = sda_in;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = START;
        div_d   = '0;
        qtr_d   = '0;
        bit_d   = 3'd7;
        sh_d    = {addr, rw};
        rw_d    = rw;
        rem_d   = (len > LEN_MAX) ? LEN_MAX : len;
        nack_d  = 1'b0;
      end
      START: if (slot_end) state_d = ADDR;
      ADDR, WR_BYTE: if (slot_end) begin
        if (bit_q == 3'd0) begin
          state_d = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
        end else begin
          bit_d = bit_q - 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
        end
      end
      ADDR_ACK, WR_ACK: if (slot_end) begin
        if (ack_q) begin
          nack_d  = 1'b1;
          state_d = STOP;
        end else if (rem_q == '0) begin
          state_d = STOP;
        end else begin
          state_d = rw_q ? RD_BYTE : WR_BYTE;
          rem_d   = rem_q - LEN_W'(1);
          bit_d   = 3'd7;
          if (!rw_q) begin
            wready = 1'b1;
            sh_d   = wdata;
          end
        end
      end
      RD_BYTE: begin
        if (smp) begin
          sh_d = {sh_q[6:0], sda_in};
          if (bit_q == 3'd0) begin
            rdata_d  = {sh_q[6:0], sda_in};
            rvalid_d = 1'b1;
          end
        end
        if (slot_end) begin
          if (bit_q == 3'd0) state_d = RD_ACK;
          else bit_d = bit_q - 3'd1;
        end
      end
      RD_ACK: if (slot_end) begin
        if (rem_q == '0) begin
          state_d = STOP;
        end else begin
          state_d = RD_BYTE;
          rem_d   = rem_q - LEN_W'(1);
          bit_d   = 3'd7;
        end
      end
      STOP: if (slot_end) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      qtr_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      rw_q     <= 1'b0;
      rem_q    <= '0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      rw_q     <= rw_d;
      rem_q    <= rem_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule
